// File: rtl/cpu_fpu_issue.sv
// FPU request/ready initiator: issues one FP op, holds operands until ready,
// hands the result to writeback, then forces one request-low cycle.
package cpu_fpu_pkg;
   localparam logic [4:0] FPU_OP_ADD        = 5'd0;
   localparam logic [4:0] FPU_OP_SUB        = 5'd1;
   localparam logic [4:0] FPU_OP_MUL        = 5'd2;
   localparam logic [4:0] FPU_OP_DIV        = 5'd3;
   localparam logic [4:0] FPU_OP_SQRT       = 5'd4;
   localparam logic [4:0] FPU_OP_MIN        = 5'd5;
   localparam logic [4:0] FPU_OP_MAX        = 5'd6;
   localparam logic [4:0] FPU_OP_FMADD      = 5'd7;
   localparam logic [4:0] FPU_OP_FMSUB      = 5'd8;
   localparam logic [4:0] FPU_OP_FNMADD     = 5'd9;
   localparam logic [4:0] FPU_OP_FNMSUB     = 5'd10;
   localparam logic [4:0] FPU_OP_I2F        = 5'd11;
   localparam logic [4:0] FPU_OP_F2I        = 5'd12;
   localparam logic [4:0] FPU_OP_MOV        = 5'd13;
   localparam logic [4:0] FPU_OP_SGNJ       = 5'd14;
   localparam logic [4:0] FPU_OP_SGNJN      = 5'd15;
   localparam logic [4:0] FPU_OP_SGNJX      = 5'd16;
   localparam logic [4:0] FPU_OP_CMP_EQUAL  = 5'd17;
   localparam logic [4:0] FPU_OP_CMP_LESS   = 5'd18;
   localparam logic [4:0] FPU_OP_CMP_LEQUAL = 5'd19;

   typedef struct packed {
      logic [4:0]  op;
      logic [31:0] op1;
      logic [31:0] op2;
      logic [31:0] op3;
   } fpu_req_t;
endpackage

module cpu_fpu_issue
   import cpu_fpu_pkg::*;
#(
   parameter int TIMEOUT   = 256,
   parameter int TAG_WIDTH = 5
) (
   input  logic                 i_clock,
   input  logic                 i_reset,
   input  logic                 i_valid,
   output logic                 o_busy,
   input  logic [4:0]           i_op,
   input  logic [31:0]          i_op1,
   input  logic [31:0]          i_op2,
   input  logic [31:0]          i_op3,
   input  logic [TAG_WIDTH-1:0] i_rd,
   input  logic                 i_flush,
   output logic                 o_fpu_request,
   output logic [4:0]           o_fpu_op,
   output logic [31:0]          o_fpu_op1,
   output logic [31:0]          o_fpu_op2,
   output logic [31:0]          o_fpu_op3,
   input  logic                 i_fpu_ready,
   input  logic [31:0]          i_fpu_result,
   output logic                 o_wb_valid,
   output logic [TAG_WIDTH-1:0] o_wb_rd,
   output logic [31:0]          o_wb_result,
   output logic                 o_wb_int,
   input  logic                 i_wb_ready,
   output logic                 o_fault
);

   localparam int WDW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WB,
      S_GAP
   } state_e;

   state_e          state_q, state_d;
   fpu_req_t        req_q;
   logic [WDW-1:0]  wd_q, wd_d;
   logic            accept, fire, expire;

   assign accept = (state_q == S_IDLE) && i_valid && !i_flush;
   assign fire   = (state_q == S_ISSUE) && !i_flush && i_fpu_ready;
   assign expire = (state_q == S_ISSUE) && !i_flush && !i_fpu_ready
                   && (wd_q == WD_MAX);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (accept) state_d = S_ISSUE;
         S_ISSUE: begin
            if (i_flush || expire) state_d = S_GAP;
            else if (fire)         state_d = S_WB;
         end
         S_WB:    if (i_flush || i_wb_ready) state_d = S_GAP;
         S_GAP:   state_d = S_IDLE;
      endcase
   end

   // Counts request cycles; zero whenever the request is not continuing.
   always_comb begin
      wd_d = '0;
      if (state_q == S_ISSUE && state_d == S_ISSUE)
         wd_d = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state_q <= S_IDLE;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         wd_q    <= wd_d;
      end
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         req_q       <= '0;
         o_wb_rd     <= '0;
         o_wb_int    <= 1'b0;
         o_wb_result <= '0;
         o_fault     <= 1'b0;
      end else begin
         if (accept) begin
            req_q    <= '{op: i_op, op1: i_op1, op2: i_op2, op3: i_op3};
            o_wb_rd  <= i_rd;
            o_wb_int <= i_op inside {FPU_OP_F2I, FPU_OP_CMP_EQUAL,
                                     FPU_OP_CMP_LESS, FPU_OP_CMP_LEQUAL};
         end
         if (fire)   o_wb_result <= i_fpu_result;
         if (expire) o_fault     <= 1'b1;
      end
   end

   // Handshake outputs decode the state flop so reset clears them at once.
   assign o_busy        = (state_q != S_IDLE);
   assign o_fpu_request = (state_q == S_ISSUE);
   assign o_wb_valid    = (state_q == S_WB);
   assign o_fpu_op      = req_q.op;
   assign o_fpu_op1     = req_q.op1;
   assign o_fpu_op2     = req_q.op2;
   assign o_fpu_op3     = req_q.op3;

endmodule

// File: doc/cpu_fpu_issue.md
Name: cpu_fpu_issue

Overview:
Initiator side of the FPU request/ready interface. It accepts one decoded floating-point operation from the execute stage and drives the FPU request, opcode and operands. It holds them stable until the FPU signals ready, then captures the result and presents it to writeback with a valid/ready handshake. It also enforces the mandatory idle cycle between FPU requests, supports pipeline flush, and detects FPU hangs with a watchdog.

Parameters:
TIMEOUT, 256, max cycles o_fpu_request may stay high without i_fpu_ready before fault
TAG_WIDTH, 5, width of destination register index carried through

Ports:
i_clock  in  1  clock
i_reset  in  1  reset, asynchronous, active-low
i_valid  in  1  execute stage presents an FP operation
o_busy  out  1  block cannot accept (i_valid ignored while high)
i_op  in  5  FPU_OP_* opcode
i_op1  in  32  operand 1
i_op2  in  32  operand 2
i_op3  in  32  operand 3 (fused ops)
i_rd  in  TAG_WIDTH  destination register index
i_flush  in  1  cancel in-flight operation
o_fpu_request  out  1  request to FPU
o_fpu_op  out  5  opcode to FPU
o_fpu_op1  out  32  operand 1 to FPU
o_fpu_op2  out  32  operand 2 to FPU
o_fpu_op3  out  32  operand 3 to FPU
i_fpu_ready  in  1  FPU result valid (qualified by request)
i_fpu_result  in  32  FPU result
o_wb_valid  out  1  result available
o_wb_rd  out  TAG_WIDTH  destination index
o_wb_result  out  32  result value
o_wb_int  out  1  destination is the integer register file
i_wb_ready  in  1  writeback accepts
o_fault  out  1  sticky watchdog fault

Behaviour:
- Reset (i_reset low, async): state IDLE. All outputs 0, including o_busy, o_fpu_request, o_fpu_op/op1-3, o_wb_* and o_fault. Watchdog counter 0.
- States: IDLE, ISSUE, WB, GAP.
- IDLE:
  - o_busy=0.
  - i_valid=1 and i_flush=0: register op, op1-3, rd and int flag. Go to ISSUE; o_fpu_request=1 in the next cycle (1 cycle accept-to-request latency).
  - The int flag is set for FPU_OP_F2I, FPU_OP_CMP_EQUAL, FPU_OP_CMP_LESS and FPU_OP_CMP_LEQUAL; it is clear otherwise.
- ISSUE:
  - o_busy=1. o_fpu_request=1. o_fpu_op and o_fpu_op1-3 are held constant every cycle.
  - Watchdog increments each cycle.
  - i_fpu_ready=1: capture i_fpu_result into o_wb_result, drop request in the next cycle, go to WB, clear watchdog.
  - Ops FPU_OP_MOV and FPU_OP_SGNJ* complete with ready in the first ISSUE cycle. Total accept-to-wb_valid latency is then 2 cycles.
- WB:
  - o_busy=1, o_wb_valid=1; o_wb_rd, o_wb_result and o_wb_int are stable.
  - When i_wb_ready=1: o_wb_valid drops in the next cycle, go to GAP.
- GAP:
  - Exactly one cycle with o_fpu_request=0 and o_busy=1; FPU sub-units re-arm on request low. Then go to IDLE.
  - Back-to-back throughput: one op per 4 cycles minimum (accept, issue, wb, gap).
- Flush:
  - In ISSUE: drop request in the next cycle and go to GAP; no wb_valid is produced, even if i_fpu_ready coincides with i_flush.
  - In WB: o_wb_valid drops in the next cycle and go to GAP.
  - In IDLE: a simultaneous i_valid is ignored.
  - In GAP: no effect.
  - Flush has priority over ready and i_wb_ready.
- Watchdog:
  - If the counter reaches TIMEOUT-1 in ISSUE without ready, set o_fault (sticky until reset), drop request, go to GAP, no writeback.
  - The counter saturates and never wraps.
- Protocol invariants:
  - o_fpu_op/op1-3 never change while o_fpu_request=1.
  - i_fpu_ready is ignored while o_fpu_request=0.
  - o_wb_valid never asserts together with o_fpu_request.
- Reset mid-operation drops request and wb_valid immediately, without waiting for the clock.

Test Plan:
- FPU_OP_ADD, op1=0x3F800000, op2=0x40000000, FPU model ready after 3 cycles with 0x40400000 -> request high 3 cycles with operands stable; wb_valid 1 cycle after ready with result 0x40400000, rd echoed, wb_int=0; gap cycle with request low before busy drops.
- FPU_OP_CMP_LESS, ready on first ISSUE cycle with 0x00000001, i_wb_ready held low 5 cycles -> wb_valid stays high with result 0x1 and wb_int=1 for 5 cycles, drops the cycle after wb_ready.
- Two back-to-back i_valid ops -> second accepted only after GAP; request low for exactly 1 cycle between the two requests; 4-cycle minimum spacing.
- i_flush asserted in the same cycle as i_fpu_ready -> no wb_valid; request low next cycle; GAP then IDLE; next op completes normally.
- FPU model never asserts ready, TIMEOUT=16 -> o_fault rises after 16 request cycles and stays high; request drops; no writeback; subsequent ops still accepted.
- Assert i_reset low during ISSUE between clock edges -> o_fpu_request, o_busy, o_fault and o_wb_valid go 0 asynchronously; after release the block is in IDLE and accepts a new op.
